mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_pkg.sv | 46 ++++
 rtl/mdu_div_core.sv | 73 +++++++
 rtl/mdu_iter.sv | 163 ++++++++++++++++
 tb/tb_mdu_iter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// control word, FSM states and small op-class decode helpers.
package mdu_pkg;

  // Codes 8..15 are left undefined on purpose; the unit accepts them and returns 0.
  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7
  } mdu_op_t;

  typedef struct packed {
    logic    enable;
    mdu_op_t operation;
  } mdu_control_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_t;

  function automatic logic is_mul_op(input mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input mdu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_div(input mdu_op_t op);
    return op inside {OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per
// cycle for REG_WIDTH cycles after start; done marks the final iteration.
module mdu_div_core #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_WIDTH-1:0] dividend,
  input  logic [REG_WIDTH-1:0] divisor,
  output logic [REG_WIDTH-1:0] quotient,
  output logic [REG_WIDTH-1:0] remainder,
  output logic                 done
);

  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(W);

  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [W:0]    shifted;
  logic [W:0]    trial;

  // The dividend shifts out of quo MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, dvs};
  end

  // NOTE: every datapath register is cleared by reset, not only the control
  // bits, so no stale quotient can leak out after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (trial[W]) begin
        rem <= shifted[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end else begin
        rem <= trial[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end
      if (cnt == CW'(W - 1)) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign done      = busy && (cnt == CW'(W - 1));
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mdu_iter.sv
// Single-slot multiply/divide unit: pipelined-latency multiply inline,
// iterative divide in mdu_div_core, valid/ready handshake on both sides.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  mdu_control_t         i_control,
  input  logic [REG_WIDTH-1:0] i_op1,
  input  logic [REG_WIDTH-1:0] i_op2,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [REG_WIDTH-1:0] o_result,
  output logic                 o_cooking
);

  localparam int W   = REG_WIDTH;
  localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  mdu_state_t   state;
  mdu_op_t      op_in;
  mdu_op_t      op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         neg_q;
  logic         neg_r;
  logic [MCW-1:0] mul_cnt;

  logic         div_zero;
  logic         div_ovf;
  logic         div_start;
  logic         div_done;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic [W-1:0] div_quo;
  logic [W-1:0] div_rem;
  logic [W-1:0] special_res;
  logic         enable_unused;

  // The control word's enable bit carries no meaning here; i_valid qualifies requests.
  assign enable_unused = i_control.enable;
  assign op_in         = i_control.operation;

  function automatic logic [W-1:0] mul_calc(input mdu_op_t op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic signed [W:0]     sa;
    logic signed [W:0]     sb;
    logic signed [2*W+1:0] p;
    sa = {(op == OP_MULH || op == OP_MULHSU) & a[W-1], a};
    sb = {(op == OP_MULH) & b[W-1], b};
    p  = sa * sb;
    return (op == OP_MUL) ? W'(p) : W'(p >>> W);
  endfunction

  // NOTE: always_comb outputs get a value on every path, so no latches form.
  always_comb begin
    div_zero    = (i_op2 == '0);
    div_ovf     = is_signed_div(op_in) && (i_op1 == MOST_NEG) && (i_op2 == '1);
    mag_a       = (is_signed_div(op_in) && i_op1[W-1]) ? -i_op1 : i_op1;
    mag_b       = (is_signed_div(op_in) && i_op2[W-1]) ? -i_op2 : i_op2;
    special_res = div_zero ? (is_rem_op(op_in) ? i_op1 : '1)
                           : (is_rem_op(op_in) ? '0 : i_op1);
    div_start   = (state == S_IDLE) && i_valid && !i_flush && is_div_op(op_in)
                  && !div_zero && !div_ovf;
  end

  mdu_div_core #(.REG_WIDTH(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (i_flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mul_cnt  <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state    <= S_IDLE;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            op_q    <= op_in;
            a_q     <= i_op1;
            b_q     <= i_op2;
            neg_q   <= is_signed_div(op_in) && (i_op1[W-1] ^ i_op2[W-1]);
            neg_r   <= is_signed_div(op_in) && i_op1[W-1];
            mul_cnt <= MCW'(1);
            if (is_mul_op(op_in)) begin
              if (MUL_STAGES == 1) begin
                state    <= S_DONE;
                o_valid  <= 1'b1;
                o_result <= mul_calc(op_in, i_op1, i_op2);
              end else begin
                state <= S_MUL;
              end
            end else if (is_div_op(op_in) && !div_zero && !div_ovf) begin
              state <= S_DIV;
            end else begin
              state    <= S_DONE;
              o_valid  <= 1'b1;
              o_result <= is_div_op(op_in) ? special_res : '0;
            end
          end
        end
        S_MUL: begin
          if (mul_cnt == MCW'(MUL_STAGES - 1)) begin
            state    <= S_DONE;
            o_valid  <= 1'b1;
            o_result <= mul_calc(op_q, a_q, b_q);
          end else begin
            mul_cnt <= mul_cnt + MCW'(1);
          end
        end
        S_DIV: begin
          if (div_done) state <= S_FIX;
        end
        S_FIX: begin
          state    <= S_DONE;
          o_valid  <= 1'b1;
          o_result <= is_rem_op(op_q) ? (neg_r ? -div_rem : div_rem)
                                      : (neg_q ? -div_quo : div_quo);
        end
        S_DONE: begin
          if (i_ready) begin
            state    <= S_IDLE;
            o_valid  <= 1'b0;
            o_result <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = (state == S_IDLE);
  assign o_cooking = (state != S_IDLE);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops
// compared against an arithmetic reference model of results and latencies.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MS = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  mdu_control_t i_control;
  logic [W-1:0] i_op1;
  logic [W-1:0] i_op2;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_cooking;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  mdu_iter #(.REG_WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_control (i_control),
    .i_op1     (i_op1),
    .i_op2     (i_op2),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_cooking (o_cooking)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions of each op.
  function automatic logic [31:0] ref_result(input int code, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (code)
      0: begin p = sa * sb; return p[31:0];  end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * ub; return p[63:32]; end
      3: begin p = ua * ub; return p[63:32]; end
      4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      7: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input int code, input logic [31:0] a, input logic [31:0] b);
    if (code <= 3) return MS;
    if (code <= 7) begin
      if (b == 0) return 1;
      if ((code == 4 || code == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 2;
    end
    return 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return 32'(0 - $urandom_range(1, 20));
      default: return corners[$urandom_range(0, 4)];
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the cycle after acceptance.
  task automatic issue(input int code, input logic [31:0] a, input logic [31:0] b);
    mdu_control_t ctl;
    ctl.enable    = 1'($urandom);
    ctl.operation = mdu_op_t'(4'(code));
    i_control = ctl;
    i_op1     = a;
    i_op2     = b;
    i_valid   = 1'b1;
    check("accept_ready", {31'h0, o_ready}, 32'h1);
    @(negedge clk);
    i_valid = 1'b0;
    i_op1   = $urandom;
    i_op2   = $urandom;
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_res, input int stall);
    int lat = 1;
    logic nonzero_idle = 1'b0;
    while (!o_valid && lat < 200) begin
      if (o_result != 0) nonzero_idle = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_zero_while_busy"}, {31'h0, nonzero_idle}, 32'h0);
    check({tag, "_res"}, o_result, exp_res);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, o_result, exp_res);
      check({tag, "_hold_flags"}, {29'h0, o_valid, o_ready, o_cooking}, 32'b101);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_idle_flags"}, {29'h0, o_valid, o_ready, o_cooking}, 32'b010);
    check({tag, "_idle_res"}, o_result, 32'h0);
  endtask

  initial begin
    int quiet;
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_control = '0; i_op1 = '0; i_op2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_flags", {29'h0, o_valid, o_ready, o_cooking}, 32'b010);
    check("reset_res", o_result, 32'h0);

    // Directed corner cases with spec-given values and latencies.
    issue(1, 32'h8000_0000, 32'h8000_0000);
    wait_result("mulh_min", 3, 32'h4000_0000, 0);
    issue(4, 32'hFFFF_FFF9, 32'h2);
    wait_result("div_m7_2", 34, 32'hFFFF_FFFD, 0);
    issue(6, 32'hFFFF_FFF9, 32'h2);
    wait_result("rem_m7_2", 34, 32'hFFFF_FFFF, 0);
    issue(5, 32'h5, 32'h0);
    wait_result("divu_zero", 1, 32'hFFFF_FFFF, 0);
    issue(7, 32'h5, 32'h0);
    wait_result("remu_zero", 1, 32'h5, 0);
    issue(4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 1, 32'h8000_0000, 0);
    issue(6, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("rem_ovf", 1, 32'h0, 0);
    issue(0, 32'h6, 32'h7);
    wait_result("mul_stall", 3, 32'h2A, 5);
    issue(12, 32'h1234, 32'h5678);
    wait_result("undef_op", 1, 32'h0, 1);

    // Flush mid-divide, then a request in the very next cycle.
    issue(5, 32'hDEAD_BEEF, 32'h3);
    repeat (9) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_div_flags", {29'h0, o_valid, o_ready, o_cooking}, 32'b010);
    issue(0, 32'h3, 32'h5);
    wait_result("after_flush", 3, 32'hF, 0);

    // Flush beats acceptance, and flush drops a held result.
    i_valid = 1'b1; i_flush = 1'b1; i_control.operation = OP_MUL;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_vs_accept", {29'h0, o_valid, o_ready, o_cooking}, 32'b010);
    issue(5, 32'h9, 32'h0);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_done_flags", {29'h0, o_valid, o_ready, o_cooking}, 32'b010);
    check("flush_done_res", o_result, 32'h0);

    // Reset mid-divide: no result may ever appear.
    issue(4, 32'h64, 32'h7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_flags", {29'h0, o_valid, o_ready, o_cooking}, 32'b010);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid || o_cooking) quiet++;
    end
    check("rst_mid_quiet", quiet, 0);

    // Random ops against the arithmetic model.
    for (int n = 0; n < 48; n++) begin
      int code;
      logic [31:0] a, b;
      code = $urandom_range(0, 9);
      a = pick();
      b = pick();
      issue(code, a, b);
      wait_result($sformatf("rnd%0d_op%0d", n, code), ref_lat(code, a, b), ref_result(code, a, b),
                  $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
